et_sng: RTL and testbench

- Early-terminating stochastic number generator; sits directly downstream of the progressive-precision mask block.
- Consumes the W-bit binary operands plus the per-group skip masks S and the one-hot scale k_init that block produces.
- Emits N bit-streams whose length is 2^(number of non-skipped bits), so short streams replace full 2^W-cycle streams.
- Drives a valid/ready stream interface into the downstream SC arithmetic/counter stage.

---
 rtl/et_sng_pkg.sv | 34 +++
 rtl/et_sng_rns_step.sv | 17 +
 rtl/et_sng.sv | 94 +++++++++
 tb/tb_et_sng.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/et_sng_pkg.sv
// Shared types and bit helpers for the early-terminating SNG.
// Helpers work on 32-bit containers; callers pass the live width.
package et_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} et_state_e;

  function automatic logic [31:0] rev32(input logic [31:0] x);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) r[i] = x[31-i];
    return r;
  endfunction

  // Reverse the low w bits; bits above w are discarded.
  function automatic logic [31:0] bit_rev(input logic [31:0] x, input int w);
    return rev32(x) >> (32 - w);
  endfunction

  // Next submask of m in van der Corput order: count in the reversed domain
  // with skipped positions forced to 1 so the carry jumps over them.
  function automatic logic [31:0] masked_inc(input logic [31:0] r, input logic [31:0] m,
                                             input int w);
    logic [31:0] rr, mr;
    rr = bit_rev(r, w);
    mr = bit_rev(m, w);
    return bit_rev(((rr | ~mr) + 32'd1) & mr, w);
  endfunction

  function automatic int popcount(input logic [31:0] x);
    int c;
    c = 0;
    for (int i = 0; i < 32; i++) c += int'(x[i]);
    return c;
  endfunction
endpackage

// File: rtl/et_sng_rns_step.sv
// One RNS group step: next submask in van der Corput order plus wrap flag.
module et_rns_step
  import et_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W-1:0] r,
  input  logic [W-1:0] M,
  output logic [W-1:0] r_next,
  output logic         wrap
);
  logic [31:0] w_full;

  assign w_full = masked_inc(32'(r), 32'(M), W);
  assign r_next = w_full[W-1:0];
  assign wrap   = ~|r_next;
endmodule

// File: rtl/et_sng.sv
// Early-terminating stochastic number generator: N comparator streams driven
// by S_GROUPS masked RNS counters chained as an odometer, valid/ready output.
module et_sng
  import et_pkg::*;
#(
  parameter int W        = 4,
  parameter int N        = 2,
  parameter int S_GROUPS = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [N-1:0][W-1:0]        Bxs,
  input  logic [S_GROUPS-1:0][W-1:0] S,
  input  logic [W-1:0]               k_init,
  output logic                       busy,
  output logic [N-1:0]               bs,
  output logic                       bs_valid,
  input  logic                       bs_ready,
  output logic                       bs_last,
  output logic [W-1:0]               k_scale,
  output logic [W:0]                 beat_cnt
);
  et_state_e                  r_state, w_state_nxt;
  logic [N-1:0][W-1:0]        r_bx;
  logic [S_GROUPS-1:0][W-1:0] r_m, r_rns, w_rns_nxt;
  logic [S_GROUPS-1:0]        w_wrap, w_step;
  logic [W-1:0]               r_k;
  logic [W:0]                 r_cnt;
  logic                       w_xfer, w_accept;

  assign bs_valid = (r_state == RUN);
  assign busy     = bs_valid;
  assign bs_last  = bs_valid & (&w_wrap);
  assign w_xfer   = bs_valid & bs_ready;
  assign w_accept = (r_state == IDLE) & start;
  assign k_scale  = r_k;
  assign beat_cnt = r_cnt;

  // Group g+1 advances only when every lower group wraps on this beat.
  for (genvar g = 0; g < S_GROUPS; g++) begin : g_grp
    et_rns_step #(.W(W)) u_step (
      .r     (r_rns[g]),
      .M     (r_m[g]),
      .r_next(w_rns_nxt[g]),
      .wrap  (w_wrap[g])
    );
    if (g == 0) begin : g_first
      assign w_step[g] = w_xfer;
    end else begin : g_chain
      assign w_step[g] = w_step[g-1] & w_wrap[g-1];
    end
  end

  for (genvar j = 0; j < N; j++) begin : g_bs
    localparam int G = (S_GROUPS == 1) ? 0 : j;
    assign bs[j] = (r_bx[j] > r_rns[G]);
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = RUN;
      RUN:     if (w_xfer && bs_last) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bx  <= '0;
      r_m   <= '0;
      r_rns <= '0;
      r_k   <= '0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_bx  <= Bxs;
      r_m   <= ~S;
      r_k   <= k_init;
      r_rns <= '0;
      r_cnt <= '0;
    end else if (w_xfer) begin
      if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
      for (int g = 0; g < S_GROUPS; g++)
        if (w_step[g]) r_rns[g] <= w_rns_nxt[g];
    end
  end
endmodule

// File: tb/tb_et_sng.sv
// Self-checking bench: one single-group and one two-group instance, checked
// against a submask-enumeration reference model with random stall patterns.
module tb_et_sng;
  import et_pkg::*;

  logic            clk = 1'b0;
  logic            rst_n, start, sel, bs_ready;
  logic [1:0][3:0] bxs;
  logic [3:0]      k_in;
  logic [0:0][3:0] s_a;
  logic [1:0][3:0] s_b;
  logic            start_a, start_b;
  logic            busy_a, valid_a, last_a, busy_b, valid_b, last_b;
  logic [1:0]      bs_a, bs_b;
  logic [3:0]      k_a, k_b;
  logic [4:0]      cnt_a, cnt_b;
  logic            m_busy, m_valid, m_last;
  logic [1:0]      m_bs;
  logic [3:0]      m_k;
  logic [4:0]      m_cnt;
  int              n_chk = 0;
  int              n_fail = 0;

  always #5 clk = ~clk;

  assign start_a = start & ~sel;
  assign start_b = start & sel;
  assign m_busy  = sel ? busy_b  : busy_a;
  assign m_valid = sel ? valid_b : valid_a;
  assign m_last  = sel ? last_b  : last_a;
  assign m_bs    = sel ? bs_b    : bs_a;
  assign m_k     = sel ? k_b     : k_a;
  assign m_cnt   = sel ? cnt_b   : cnt_a;

  et_sng #(.W(4), .N(2), .S_GROUPS(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .Bxs(bxs), .S(s_a), .k_init(k_in),
    .busy(busy_a), .bs(bs_a), .bs_valid(valid_a), .bs_ready(bs_ready),
    .bs_last(last_a), .k_scale(k_a), .beat_cnt(cnt_a));

  et_sng #(.W(4), .N(2), .S_GROUPS(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .Bxs(bxs), .S(s_b), .k_init(k_in),
    .busy(busy_b), .bs(bs_b), .bs_valid(valid_b), .bs_ready(bs_ready),
    .bs_last(last_b), .k_scale(k_b), .beat_cnt(cnt_b));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: beat index c enumerates the submasks of m, with the LSB of c
  // landing on the highest unmasked bit (fastest toggling).
  function automatic logic [3:0] spread(input int c, input logic [3:0] m);
    logic [3:0] r;
    int b;
    r = '0;
    b = 0;
    for (int p = 3; p >= 0; p--)
      if (m[p]) begin
        r[p] = c[b];
        b++;
      end
    return r;
  endfunction

  task automatic run_stream(input logic s_sel, input logic [1:0][3:0] bx,
                            input logic [1:0][3:0] s, input logic [3:0] k,
                            input int mode, input bit done_poke, output int ones0);
    int         p0, p1, len, t, cyc;
    logic [3:0] m0, m1, r0, r1;
    logic [1:0] e_bs;
    m0 = ~s[0];
    m1 = s_sel ? ~s[1] : 4'h0;
    p0 = popcount(32'(m0));
    p1 = popcount(32'(m1));
    len = 1 << (p0 + p1);
    ones0 = 0;
    @(negedge clk);
    sel = s_sel; bxs = bx; s_a[0] = s[0]; s_b = s; k_in = k; bs_ready = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_rise", 32'(m_busy), 1);
    chk("k_scale", 32'(m_k), 32'(k));
    t = 0;
    cyc = 0;
    while (t < len && cyc < 2000) begin
      case (mode)
        0:       bs_ready = 1'b1;
        1:       bs_ready = 1'($urandom_range(0, 1));
        default: bs_ready = (cyc % 3 == 0);
      endcase
      if (mode == 1) begin
        start = 1'($urandom_range(0, 1));
        bxs = 8'($urandom);
      end
      r0 = spread(t % (1 << p0), m0);
      r1 = s_sel ? spread(t >> p0, m1) : r0;
      e_bs[0] = bx[0] > r0;
      e_bs[1] = bx[1] > r1;
      #1;
      chk("valid", 32'(m_valid), 1);
      chk("bs", 32'(m_bs), 32'(e_bs));
      chk("last", 32'(m_last), 32'(t == len - 1));
      chk("cnt_run", 32'(m_cnt), 32'(t > 31 ? 31 : t));
      @(posedge clk);
      if (bs_ready) begin
        ones0 += int'(e_bs[0]);
        t++;
      end
      cyc++;
      @(negedge clk);
    end
    if (t < len) chk("timeout", 32'(t), 32'(len));
    start = 1'b0;
    bxs = bx;
    chk("done_busy", 32'(m_busy), 0);
    chk("done_valid", 32'(m_valid), 0);
    chk("cnt_end", 32'(m_cnt), 32'(len > 31 ? 31 : len));
    if (done_poke) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("idle_busy", 32'(m_busy), 0);
    @(negedge clk);
    chk("idle_busy2", 32'(m_busy), 0);
  endtask

  initial begin
    int ones;
    rst_n = 1'b0; start = 1'b0; sel = 1'b0; bs_ready = 1'b0;
    bxs = '0; k_in = '0; s_a = '0; s_b = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(m_busy), 0);
    chk("rst_valid", 32'(m_valid), 0);
    chk("rst_last", 32'(m_last), 0);
    chk("rst_bs", 32'(m_bs), 0);
    chk("rst_k", 32'(m_k), 0);
    chk("rst_cnt", 32'(m_cnt), 0);
    rst_n = 1'b1;

    run_stream(1'b0, 8'b0100_0110, 8'b0000_1001, 4'b1000, 0, 1'b0, ones);
    run_stream(1'b0, 8'b0100_0110, 8'b0000_1001, 4'b1000, 2, 1'b1, ones);
    run_stream(1'b1, 8'b0100_1000, 8'b1101_1110, 4'b0100, 0, 1'b0, ones);
    run_stream(1'b0, 8'b0000_0011, 8'b0000_1111, 4'b0010, 0, 1'b0, ones);
    run_stream(1'b0, 8'b1111_0101, 8'b0000_0000, 4'b0001, 0, 1'b0, ones);
    chk("ones16", 32'(ones), 5);

    // Reset in the middle of beat 2, then replay from r=0.
    @(negedge clk);
    sel = 1'b0; bxs = 8'b0100_0110; s_a[0] = 4'b1001; k_in = 4'b1000;
    bs_ready = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(m_busy), 0);
    chk("mid_rst_valid", 32'(m_valid), 0);
    chk("mid_rst_cnt", 32'(m_cnt), 0);
    chk("mid_rst_k", 32'(m_k), 0);
    chk("mid_rst_bs", 32'(m_bs), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_stream(1'b0, 8'b0100_0110, 8'b0000_1001, 4'b1000, 0, 1'b0, ones);

    for (int i = 0; i < 14; i++)
      run_stream(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
                 4'(1 << $urandom_range(0, 3)), 1, 1'($urandom_range(0, 1)), ones);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
